// File: rtl/secuenciador_serie_pkg.sv
// Shared types and constants for the bit-serial word sequencer feeding the 4:1 registered mux.
package secuenciador_serie_pkg;

    localparam int unsigned DATA_W_DEF   = 4;
    localparam int unsigned SEL_W_DEF    = 2;
    localparam int unsigned WORD_CNT_W   = 8;
    localparam int unsigned WORD_CNT_MOD = 256;
    localparam int unsigned GAP_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Single-bit status outputs, registered together.
    typedef struct packed {
        logic ready;
        logic busy;
        logic frame_start;
        logic frame_end;
    } flags_t;

    localparam flags_t FLAGS_RST = '{ready: 1'b1, busy: 1'b0, frame_start: 1'b0, frame_end: 1'b0};

    // First and last selector codes of a word for the chosen bit order.
    function automatic int unsigned sel_start(input int unsigned data_w, input bit msb_first);
        return msb_first ? data_w - 1 : 0;
    endfunction

    function automatic int unsigned sel_end(input int unsigned data_w, input bit msb_first);
        return msb_first ? 0 : data_w - 1;
    endfunction

endpackage

// File: rtl/secuenciador_serie_contador_mod_n.sv
// Modulo-MOD up-counter with synchronous reset, load and enable; o_wrap flags the terminal count.
module contador_mod_n
    import secuenciador_serie_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MOD   = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == LAST);

endmodule

// File: rtl/secuenciador_serie.sv
// Accepts a parallel word over valid/ready and sweeps the mux selector so the mux emits it
// bit-serially, with frame pulses, an idle gap after each word and a sent-word counter.
module secuenciador_serie
    import secuenciador_serie_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_word,
    output logic                  o_ready,
    output logic [DATA_W-1:0]     o_data,
    output logic [SEL_W-1:0]      o_selector,
    output logic                  o_busy,
    output logic                  o_frame_start,
    output logic                  o_frame_end,
    output logic [WORD_CNT_W-1:0] o_word_cnt
);

    localparam bit               MSB        = (MSB_FIRST != 0);
    localparam logic [SEL_W-1:0] SEL_FIRST  = SEL_W'(sel_start(DATA_W, MSB));
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(sel_end(DATA_W, MSB));
    localparam int unsigned      GAP_MOD    = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [SEL_W-1:0]    w_sel_step;
    flags_t              r_flags;
    flags_t              w_flags_nxt;

    logic                w_word_done;
    logic                w_gap_load;
    logic                w_gap_en;
    logic                w_gap_done;
    logic [GAP_CNT_W-1:0] w_gap_cnt;
    logic                w_unused_word_wrap;

    // Selector direction is fixed by the bit order, so it stays outside the counters.
    assign w_sel_step = MSB ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_sel   <= '0;
            r_flags <= FLAGS_RST;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        w_word_done = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_en    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_data_nxt  = i_word;
                    w_sel_nxt   = SEL_FIRST;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (r_sel == SEL_LAST) begin
                    w_word_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_gap_load  = 1'b1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_sel_nxt = w_sel_step;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Flags are registered from the next state so they line up with o_selector.
        w_flags_nxt.ready       = (w_state_nxt == ST_IDLE);
        w_flags_nxt.busy        = (w_state_nxt != ST_IDLE);
        w_flags_nxt.frame_start = (r_state == ST_IDLE) && (w_state_nxt == ST_SEND);
        w_flags_nxt.frame_end   = (w_state_nxt == ST_SEND) && (w_sel_nxt == SEL_LAST);
    end

    contador_mod_n #(
        .WIDTH (GAP_CNT_W),
        .MOD   (GAP_MOD)
    ) u_gap_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_gap_en),
        .i_load (w_gap_load),
        .i_val  ('0),
        .o_cnt  (w_gap_cnt),
        .o_wrap (w_gap_done)
    );

    contador_mod_n #(
        .WIDTH (WORD_CNT_W),
        .MOD   (WORD_CNT_MOD)
    ) u_word_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_word_done),
        .i_load (1'b0),
        .i_val  ('0),
        .o_cnt  (o_word_cnt),
        .o_wrap (w_unused_word_wrap)
    );

    assign o_ready       = r_flags.ready;
    assign o_busy        = r_flags.busy;
    assign o_frame_start = r_flags.frame_start;
    assign o_frame_end   = r_flags.frame_end;
    assign o_data        = r_data;
    assign o_selector    = r_sel;

    // Gap count value is only observed through its terminal-count flag.
    logic w_unused_gap_cnt;
    assign w_unused_gap_cnt = ^w_gap_cnt;

endmodule

// File: tb/tb_secuenciador_serie.sv
// Bench for secuenciador_serie: three configurations (LSB-first gap 1, MSB-first gap 1, gap 0)
// checked every cycle against a timeline model, plus a behavioural stand-in for the registered mux.
module tb_secuenciador_serie;

    logic       clk;
    logic       tb_rst   [3];
    logic       tb_valid [3];
    logic [3:0] tb_word  [3];
    logic       o_ready  [3];
    logic [3:0] o_data   [3];
    logic [1:0] o_sel    [3];
    logic       o_busy   [3];
    logic       o_fs     [3];
    logic       o_fe     [3];
    logic [7:0] o_cnt    [3];

    logic       pend_q [3];
    logic       tb_q   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cyc  = 0;

    // Model: cycles elapsed since the accept edge (0 = idle), held word, selector after a word, count.
    int m_e    [3];
    int m_data [3];
    int m_last [3];
    int m_cnt  [3];
    bit m_ok   [3];

    initial clk = 1'b0;
    always #50 clk = ~clk;

    secuenciador_serie #(.DATA_W(4), .SEL_W(2), .GAP_CYCLES(1), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_rst(tb_rst[0]), .i_valid(tb_valid[0]), .i_word(tb_word[0]),
        .o_ready(o_ready[0]), .o_data(o_data[0]), .o_selector(o_sel[0]), .o_busy(o_busy[0]),
        .o_frame_start(o_fs[0]), .o_frame_end(o_fe[0]), .o_word_cnt(o_cnt[0]));

    secuenciador_serie #(.DATA_W(4), .SEL_W(2), .GAP_CYCLES(1), .MSB_FIRST(1)) u_msb (
        .i_clk(clk), .i_rst(tb_rst[1]), .i_valid(tb_valid[1]), .i_word(tb_word[1]),
        .o_ready(o_ready[1]), .o_data(o_data[1]), .o_selector(o_sel[1]), .o_busy(o_busy[1]),
        .o_frame_start(o_fs[1]), .o_frame_end(o_fe[1]), .o_word_cnt(o_cnt[1]));

    secuenciador_serie #(.DATA_W(4), .SEL_W(2), .GAP_CYCLES(0), .MSB_FIRST(0)) u_gap0 (
        .i_clk(clk), .i_rst(tb_rst[2]), .i_valid(tb_valid[2]), .i_word(tb_word[2]),
        .o_ready(o_ready[2]), .o_data(o_data[2]), .o_selector(o_sel[2]), .o_busy(o_busy[2]),
        .o_frame_start(o_fs[2]), .o_frame_end(o_fe[2]), .o_word_cnt(o_cnt[2]));

    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        for (int i = 0; i < 3; i++) tb_q[i] <= pend_q[i];
    end

    function automatic int gap_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic int idx(input int i, input int k);
        return (i == 1) ? 3 - k : k;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc%0d: got %0d expected %0d", nm, i, tb_cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #10;
    endtask

    // Called at posedge+10; holds valid until an edge where ready was high.
    task automatic send(input int i, input logic [3:0] w);
        bit done;
        bit rd;
        done = 1'b0;
        tb_valid[i] = 1'b1;
        tb_word[i]  = w;
        for (int n = 0; n < 40 && !done; n++) begin
            rd = o_ready[i];
            @(posedge clk);
            #10;
            if (rd) done = 1'b1;
        end
        tb_valid[i] = 1'b0;
        chk("send_accept", i, int'(done), 1);
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = m_e[i];
                if (m_ok[i]) begin
                    chk("ready", i, int'(o_ready[i]), (e == 0) ? 1 : 0);
                    chk("busy",  i, int'(o_busy[i]),  (e != 0) ? 1 : 0);
                    chk("fstart", i, int'(o_fs[i]),   (e == 1) ? 1 : 0);
                    chk("fend",  i, int'(o_fe[i]),    (e == 4) ? 1 : 0);
                    chk("data",  i, int'(o_data[i]),  m_data[i]);
                    chk("sel",   i, int'(o_sel[i]),   (e >= 1 && e <= 4) ? idx(i, e - 1) : m_last[i]);
                    chk("cnt",   i, int'(o_cnt[i]),   m_cnt[i]);
                end
                pend_q[i] = o_data[i][o_sel[i]];
                if (tb_rst[i]) begin
                    m_e[i] = 0; m_data[i] = 0; m_last[i] = 0; m_cnt[i] = 0; m_ok[i] = 1'b1;
                end else if (m_e[i] > 0) begin
                    m_e[i] = m_e[i] + 1;
                    if (m_e[i] == 5) begin
                        m_cnt[i]  = (m_cnt[i] + 1) % 256;
                        m_last[i] = idx(i, 3);
                    end
                    if (m_e[i] > 4 + gap_of(i)) m_e[i] = 0;
                end else if (tb_valid[i]) begin
                    m_e[i]    = 1;
                    m_data[i] = int'(tb_word[i]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d of %0d checks failed", n_fail, n_tests);
        $fatal(1, "watchdog");
    end

    int s1_sel [4] = '{0, 1, 2, 3};
    int s1_q   [4] = '{1, 0, 0, 1};
    int s2_sel [4] = '{3, 2, 1, 0};
    int s2_q   [4] = '{1, 1, 0, 0};

    initial begin
        int  acc [3];
        int  nacc;
        int  cnt_low;
        int  rel_cyc;
        bit  rd;
        bit  bz;

        for (int i = 0; i < 3; i++) begin
            tb_rst[i] = 1'b1; tb_valid[i] = 1'b0; tb_word[i] = 4'h0;
            m_e[i] = 0; m_data[i] = 0; m_last[i] = 0; m_cnt[i] = 0; m_ok[i] = 1'b0;
        end
        // Word already valid during reset must be taken on the first cycle after it.
        tb_valid[2] = 1'b1;
        tb_word[2]  = 4'h6;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) tb_rst[i] = 1'b0;
        rel_cyc = tb_cyc;
        chk("rst_ready", 0, int'(o_ready[0]), 1);
        chk("rst_cnt",   0, int'(o_cnt[0]),   0);
        chk("rst_sel",   1, int'(o_sel[1]),   0);

        // GAP_CYCLES=0: back-to-back words five cycles apart, one idle cycle between.
        nacc = 0; cnt_low = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        for (int n = 0; n < 40 && nacc < 3; n++) begin
            rd = o_ready[2];
            bz = o_busy[2];
            if (nacc == 1 && !bz) cnt_low++;
            @(posedge clk);
            #10;
            if (rd) begin
                acc[nacc] = tb_cyc;
                if (nacc == 0) begin
                    chk("s4_first_data", 2, int'(o_data[2]), 6);
                    chk("s4_first_fs",   2, int'(o_fs[2]),   1);
                end
                nacc++;
                tb_word[2] = 4'h9;
            end
        end
        tb_valid[2] = 1'b0;
        chk("s4_naccept",  2, nacc, 3);
        chk("s4_after_rst", 2, acc[0] - rel_cyc, 1);
        chk("s4_period1",  2, acc[1] - acc[0], 5);
        chk("s4_period2",  2, acc[2] - acc[1], 5);
        chk("s4_idle_gap", 2, cnt_low, 1);
        wait_cyc(6);

        // Reset on the second SEND cycle aborts the word.
        send(0, 4'hF);
        wait_cyc(1);
        chk("s5_sel_before", 0, int'(o_sel[0]), 1);
        tb_rst[0] = 1'b1;
        wait_cyc(1);
        tb_rst[0] = 1'b0;
        chk("s5_ready", 0, int'(o_ready[0]), 1);
        chk("s5_sel",   0, int'(o_sel[0]),   0);
        chk("s5_data",  0, int'(o_data[0]),  0);
        chk("s5_cnt",   0, int'(o_cnt[0]),   0);
        chk("s5_fend",  0, int'(o_fe[0]),    0);
        wait_cyc(3);
        chk("s5_fend_late", 0, int'(o_fe[0]), 0);

        // LSB first, word 1001.
        send(0, 4'b1001);
        for (int k = 0; k < 4; k++) begin
            chk("s1_sel",  0, int'(o_sel[0]), s1_sel[k]);
            chk("s1_fend", 0, int'(o_fe[0]),  (k == 3) ? 1 : 0);
            wait_cyc(1);
            chk("s1_q", 0, int'(tb_q[0]), s1_q[k]);
        end
        chk("s1_cnt", 0, int'(o_cnt[0]), 1);

        // MSB first, word 1100.
        send(1, 4'b1100);
        for (int k = 0; k < 4; k++) begin
            chk("s2_sel",  1, int'(o_sel[1]), s2_sel[k]);
            chk("s2_fend", 1, int'(o_fe[1]),  (k == 3) ? 1 : 0);
            wait_cyc(1);
            chk("s2_q", 1, int'(tb_q[1]), s2_q[k]);
        end

        // Valid held with A then 5: accepts six cycles apart, 5 ignored while sending A.
        tb_valid[0] = 1'b1;
        tb_word[0]  = 4'hA;
        nacc = 0; cnt_low = 0;
        acc[0] = 0; acc[1] = 0;
        for (int n = 0; n < 40 && nacc < 2; n++) begin
            rd = o_ready[0];
            if (nacc == 1 && !rd) cnt_low++;
            @(posedge clk);
            #10;
            if (rd) begin
                acc[nacc] = tb_cyc;
                chk("s3_data", 0, int'(o_data[0]), (nacc == 0) ? 10 : 5);
                nacc++;
                tb_word[0] = 4'h5;
            end
        end
        tb_valid[0] = 1'b0;
        chk("s3_naccept", 0, nacc, 2);
        chk("s3_period",  0, acc[1] - acc[0], 6);
        chk("s3_not_rdy", 0, cnt_low, 5);
        wait_cyc(4);
        chk("s3_cnt", 0, int'(o_cnt[0]), 3);

        // 256 more words: counter passes 255 and wraps to 0.
        for (int n = 0; n < 252; n++) send(0, 4'(n));
        wait_cyc(4);
        chk("s6_cnt255", 0, int'(o_cnt[0]), 255);
        send(0, 4'hE);
        wait_cyc(4);
        chk("s6_cnt_wrap", 0, int'(o_cnt[0]), 0);
        for (int n = 0; n < 3; n++) send(0, 4'(n + 3));
        wait_cyc(4);
        chk("s6_cnt_end", 0, int'(o_cnt[0]), 3);

        wait_cyc(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
